// File: rtl/vram_scroll_master_pkg.sv
// Shared types and constants for the VRAM scroll master.
package vram_scroll_pkg;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, INS, FIN} state_e;

  localparam logic [3:0] BYTE_EN_ALL     = 4'b1111;
  localparam int         VRAM_WINDOW_BIT = 9;

endpackage

// File: rtl/vram_scroll_master_if.sv
// Avalon-MM bus between the scroll master and the VGA VRAM slave.
interface vram_scroll_master_if #(
  parameter int ADDR_W = 10
);
  logic              AVL_READ;
  logic              AVL_WRITE;
  logic              AVL_CS;
  logic [3:0]        AVL_BYTE_EN;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [31:0]       AVL_WRITEDATA;
  logic [31:0]       AVL_READDATA;

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/vram_scroll_master.sv
// Scrolls LINES VRAM words down by one row (highest first) and inserts
// NEW_WORD at row 0. Two-cycle reads, single-cycle writes, all outputs registered.
module vram_scroll_master
  import vram_scroll_pkg::*;
#(
  parameter int LINES  = 480,
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] NEW_WORD,
  output logic        BUSY,
  output logic        DONE,
  vram_scroll_master_if.master avl
);

  localparam int              IDX_W    = VRAM_WINDOW_BIT;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINES - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        nw_q;
  logic [31:0]        wdata_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               read_q;
  logic               write_q;
  logic               busy_q;
  logic               done_q;

  // Output registers are loaded with the values of the state being entered,
  // so every output is a flop and nothing flows combinationally from inputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nw_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            nw_q   <= NEW_WORD;
            idx_q  <= IDX_LAST;
            busy_q <= 1'b1;
            if (LINES > 1) begin
              state_q <= RD1;
              read_q  <= 1'b1;
              addr_q  <= ADDR_W'(IDX_LAST - IDX_W'(1));
            end else begin
              state_q <= INS;
              write_q <= 1'b1;
              addr_q  <= '0;
              wdata_q <= NEW_WORD;
            end
          end
        end
        RD1: state_q <= RD2;
        RD2: begin
          // Slave data is valid at the end of the second read cycle.
          state_q <= WR;
          read_q  <= 1'b0;
          write_q <= 1'b1;
          addr_q  <= ADDR_W'(idx_q);
          wdata_q <= avl.AVL_READDATA;
        end
        WR: begin
          if (idx_q == IDX_W'(1)) begin
            state_q <= INS;
            addr_q  <= '0;
            wdata_q <= nw_q;
          end else begin
            state_q <= RD1;
            idx_q   <= idx_q - IDX_W'(1);
            write_q <= 1'b0;
            read_q  <= 1'b1;
            addr_q  <= ADDR_W'(idx_q - IDX_W'(2));
            wdata_q <= '0;
          end
        end
        INS: begin
          state_q <= FIN;
          write_q <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign avl.AVL_READ      = read_q;
  assign avl.AVL_WRITE     = write_q;
  assign avl.AVL_CS        = read_q | write_q;
  assign avl.AVL_BYTE_EN   = BYTE_EN_ALL;
  assign avl.AVL_ADDR      = addr_q;
  assign avl.AVL_WRITEDATA = wdata_q;

endmodule
